commit_monitor: RTL and testbench

//  Synthesizable retire-side monitor for the mp3 pipeline: assigns RVFI order numbers to up to NUM_CH

---
 rtl/commit_monitor_pkg.sv | 19 +
 rtl/commit_prefix_count.sv | 32 +++
 rtl/commit_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_commit_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/commit_monitor_pkg.sv
// -----------------------------------------------------------------------------
// commit_monitor_pkg
// Shared types for the retire-side commit monitor.
//   cm_state_e : monitor FSM states
//     CM_RUN       - normal retirement, loop and watchdog detection active
//     CM_HALT_PEND - final loop hit seen, waiting for the last writebacks to land
//     CM_HALTED    - program finished, all inputs ignored
//     CM_TIMEOUT   - no instruction retired for too long, all inputs ignored
// -----------------------------------------------------------------------------
package commit_monitor_pkg;

  typedef enum logic [1:0] {
    CM_RUN       = 2'd0,
    CM_HALT_PEND = 2'd1,
    CM_HALTED    = 2'd2,
    CM_TIMEOUT   = 2'd3
  } cm_state_e;

endpackage

// File: rtl/commit_prefix_count.sv
// -----------------------------------------------------------------------------
// commit_prefix_count
// Exclusive prefix popcount over an N-bit vector.
//   bits_i   : input vector (one bit per retire channel)
//   prefix_o : prefix_o[i] = number of set bits in bits_i[i-1:0]
//   total_o  : number of set bits in bits_i
// The top uses the prefix both to number the retiring instructions and to find
// the highest-index committing channel (the one whose prefix equals total-1).
// -----------------------------------------------------------------------------
module commit_prefix_count #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         bits_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);

  logic [CW-1:0] acc;

  // Running sum: each channel sees the count of set bits strictly below it.
  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < N; i++) begin
      prefix_o[i] = acc;
      acc         = acc + CW'(bits_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/commit_monitor.sv
// -----------------------------------------------------------------------------
// commit_monitor
// Retire-side monitor: numbers up to NUM_CH retiring instructions per cycle
// (RVFI order), detects the jump-to-self end-of-program loop and raises halt,
// and raises a watchdog timeout when nothing retires for WDOG_CYCLES cycles.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous reset, active low
//   commit_i       : channel i retires an instruction this cycle
//   pc_rdata_i     : PC of each retiring instruction
//   pc_wdata_i     : next PC of each retiring instruction
//   order_o        : order number per channel (meaningful when commit_i[i])
//   order_total_o  : instructions retired so far (registered)
//   halt_o         : program halted (sticky)
//   halted_pc_o    : PC of the loop instruction that caused the halt
//   timeout_o      : watchdog expired (sticky)
//   error_o        : strict-check violation (sticky)
//
// Optional feature macro: COMMIT_MONITOR_STRICT_EN
//   When defined, error_o flags non-contiguous commit vectors and broken PC
//   chains while in RUN/HALT_PEND. When undefined, error_o is tied low and no
//   PC-chain register exists.
// -----------------------------------------------------------------------------
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int XLEN        = 32,
  parameter int ORDER_W     = 64,
  parameter int HALT_REPEAT = 1,
  parameter int HALT_DELAY  = 1,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               commit_i,
  input  logic [NUM_CH-1:0][XLEN-1:0]     pc_rdata_i,
  input  logic [NUM_CH-1:0][XLEN-1:0]     pc_wdata_i,
  output logic [NUM_CH-1:0][ORDER_W-1:0]  order_o,
  output logic [ORDER_W-1:0]              order_total_o,
  output logic                            halt_o,
  output logic [XLEN-1:0]                 halted_pc_o,
  output logic                            timeout_o,
  output logic                            error_o
);

  localparam int CW    = $clog2(NUM_CH + 1);
  localparam int HI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam int DLY_W = $clog2(HALT_DELAY + 1);
  localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

  cm_state_e              state_q;
  logic [ORDER_W-1:0]     order_total_q;
  logic [REP_W-1:0]       rep_cnt_q,  rep_cnt_d;
  logic [DLY_W-1:0]       dly_cnt_q,  dly_cnt_d;
  logic [WD_W-1:0]        wdog_cnt_q, wdog_cnt_d;
  logic                   halt_q;
  logic                   timeout_q;
  logic [XLEN-1:0]        halted_pc_q;

  logic [NUM_CH-1:0][CW-1:0] prefix;
  logic [CW-1:0]             commit_total;
  logic [HI_W-1:0]           hi_idx;
  logic                      any_commit;
  logic                      hi_loop;
  logic                      final_hit;

  commit_prefix_count #(
    .N  (NUM_CH),
    .CW (CW)
  ) u_prefix (
    .bits_i   (commit_i),
    .prefix_o (prefix),
    .total_o  (commit_total)
  );

  // Order numbers are combinational so the RVFI hookup sees them in the same
  // cycle the instruction retires.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      order_o[i] = order_total_q + ORDER_W'(prefix[i]);
    end
  end

  // The highest committing channel is the one whose prefix count is one less
  // than the total; only that channel is tested for a jump-to-self.
  always_comb begin
    any_commit = |commit_i;
    hi_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (commit_i[i] && (prefix[i] == (commit_total - CW'(1)))) begin
        hi_idx = HI_W'(i);
      end
    end
    hi_loop   = any_commit && (pc_wdata_i[hi_idx] == pc_rdata_i[hi_idx]);
    final_hit = hi_loop && (rep_cnt_d == REP_W'(HALT_REPEAT));
  end

  // Candidate counter values; the FSM decides which ones are actually taken.
  // Idle cycles leave the loop-repeat count alone, any commit clears the
  // watchdog before it could expire.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (any_commit) begin
      rep_cnt_d = hi_loop ? (rep_cnt_q + REP_W'(1)) : '0;
    end
    wdog_cnt_d = any_commit ? '0 : (wdog_cnt_q + WD_W'(1));
    dly_cnt_d  = dly_cnt_q - DLY_W'(1);
  end

  // Monitor FSM with registered outputs. The loop hit is checked before the
  // watchdog so it wins if both land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CM_RUN;
      order_total_q <= '0;
      rep_cnt_q     <= '0;
      dly_cnt_q     <= '0;
      wdog_cnt_q    <= '0;
      halt_q        <= 1'b0;
      timeout_q     <= 1'b0;
      halted_pc_q   <= '0;
    end else begin
      unique case (state_q)
        CM_RUN: begin
          order_total_q <= order_total_q + ORDER_W'(commit_total);
          rep_cnt_q     <= rep_cnt_d;
          wdog_cnt_q    <= wdog_cnt_d;
          if (final_hit) begin
            halted_pc_q <= pc_rdata_i[hi_idx];
            dly_cnt_q   <= DLY_W'(HALT_DELAY);
            state_q     <= CM_HALT_PEND;
          end else if (wdog_cnt_d == WD_W'(WDOG_CYCLES)) begin
            timeout_q <= 1'b1;
            state_q   <= CM_TIMEOUT;
          end
        end
        CM_HALT_PEND: begin
          order_total_q <= order_total_q + ORDER_W'(commit_total);
          dly_cnt_q     <= dly_cnt_d;
          if (dly_cnt_d == '0) begin
            halt_q  <= 1'b1;
            state_q <= CM_HALTED;
          end
        end
        CM_HALTED, CM_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= CM_RUN;
        end
      endcase
    end
  end

  assign order_total_o = order_total_q;
  assign halt_o        = halt_q;
  assign halted_pc_o   = halted_pc_q;
  assign timeout_o     = timeout_q;

`ifdef COMMIT_MONITOR_STRICT_EN
  logic [XLEN-1:0] exp_pc_q;
  logic            exp_pc_vld_q;
  logic            error_q;
  logic [XLEN-1:0] chain_pc;
  logic            chain_vld;
  logic            strict_viol;

  // Walk the committing channels in order: each must start where the
  // previous retired instruction (this cycle or an earlier one) pointed.
  // A gap in commit_i is caught by x & (x+1) being non-zero.
  always_comb begin
    chain_pc    = exp_pc_q;
    chain_vld   = exp_pc_vld_q;
    strict_viol = ((commit_i & (commit_i + NUM_CH'(1))) != '0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (commit_i[i]) begin
        if (chain_vld && (pc_rdata_i[i] != chain_pc)) begin
          strict_viol = 1'b1;
        end
        chain_pc  = pc_wdata_i[i];
        chain_vld = 1'b1;
      end
    end
  end

  // PC chain and sticky error only advance while instructions are still
  // being accepted; the first commit after reset has nothing to compare to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_pc_q     <= '0;
      exp_pc_vld_q <= 1'b0;
      error_q      <= 1'b0;
    end else if ((state_q == CM_RUN) || (state_q == CM_HALT_PEND)) begin
      if (any_commit) begin
        exp_pc_q     <= chain_pc;
        exp_pc_vld_q <= 1'b1;
      end
      if (strict_viol) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// -----------------------------------------------------------------------------
// tb_commit_monitor
// Directed bench for commit_monitor (NUM_CH=2, HALT_REPEAT=3, HALT_DELAY=1,
// WDOG_CYCLES=8). The driver applies one vector per cycle and queues the
// outputs expected while that vector is applied; an independent monitor pops
// the queue at each falling edge and compares.
// Honours COMMIT_MONITOR_STRICT_EN for the expected error_o values.
// -----------------------------------------------------------------------------
module tb_commit_monitor;

  localparam int NUM_CH  = 2;
  localparam int XLEN    = 32;
  localparam int ORDER_W = 64;

`ifdef COMMIT_MONITOR_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [63:0] o0;
    logic [63:0] o1;
    logic [63:0] tot;
    logic        halt;
    logic [31:0] hpc;
    logic        to;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_CH-1:0]              commit;
  logic [NUM_CH-1:0][XLEN-1:0]    pc_r;
  logic [NUM_CH-1:0][XLEN-1:0]    pc_w;
  logic [NUM_CH-1:0][ORDER_W-1:0] order;
  logic [ORDER_W-1:0]             order_total;
  logic                           halt;
  logic [XLEN-1:0]                halted_pc;
  logic                           timeout;
  logic                           error;

  always #5 clk = ~clk;

  commit_monitor #(
    .NUM_CH      (NUM_CH),
    .XLEN        (XLEN),
    .ORDER_W     (ORDER_W),
    .HALT_REPEAT (3),
    .HALT_DELAY  (1),
    .WDOG_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit_i      (commit),
    .pc_rdata_i    (pc_r),
    .pc_wdata_i    (pc_w),
    .order_o       (order),
    .order_total_o (order_total),
    .halt_o        (halt),
    .halted_pc_o   (halted_pc),
    .timeout_o     (timeout),
    .error_o       (error)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show meanwhile.
  task automatic applyStimulus(input string name, input logic rst_n, input logic [1:0] c,
                               input logic [31:0] r0, input logic [31:0] w0,
                               input logic [31:0] r1, input logic [31:0] w1,
                               input int e0, input int e1, input int etot,
                               input logic ehalt, input logic [31:0] ehpc,
                               input logic eto, input logic eerr);
    exp_t e;
    rst     = rst_n;
    commit  = c;
    pc_r[0] = r0;
    pc_w[0] = w0;
    pc_r[1] = r1;
    pc_w[1] = w1;
    e.name  = name;
    e.o0    = 64'(e0);
    e.o1    = 64'(e1);
    e.tot   = 64'(etot);
    e.halt  = ehalt;
    e.hpc   = ehpc;
    e.to    = eto;
    e.err   = STRICT ? eerr : 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.name, ".order0"}, order[0], mon_e.o0);
        checkOutput({mon_e.name, ".order1"}, order[1], mon_e.o1);
        checkOutput({mon_e.name, ".total"}, order_total, mon_e.tot);
        checkOutput({mon_e.name, ".halt"}, 64'(halt), 64'(mon_e.halt));
        checkOutput({mon_e.name, ".halted_pc"}, 64'(halted_pc), 64'(mon_e.hpc));
        checkOutput({mon_e.name, ".timeout"}, 64'(timeout), 64'(mon_e.to));
        checkOutput({mon_e.name, ".error"}, 64'(error), 64'(mon_e.err));
      end
    end
  end

  initial begin
    rst    = 1'b0;
    commit = '0;
    pc_r   = '0;
    pc_w   = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, then three dual commits numbered in pairs.
    applyStimulus("rst_state", 1, 2'b00, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0);
    applyStimulus("pair0",     1, 2'b11, 'h00, 'h04, 'h04, 'h08, 0, 1, 0,    0, 0, 0, 0);
    applyStimulus("pair1",     1, 2'b11, 'h08, 'h0c, 'h0c, 'h10, 2, 3, 2,    0, 0, 0, 0);
    applyStimulus("pair2",     1, 2'b11, 'h10, 'h14, 'h14, 'h18, 4, 5, 4,    0, 0, 0, 0);
    // Channel 1 alone: numbered at the running total; a gap for the strict check.
    applyStimulus("ch1_only",  1, 2'b10, 0, 0, 'h18, 'h1c,       6, 6, 6,    0, 0, 0, 0);
    applyStimulus("after_gap", 1, 2'b00, 0, 0, 0, 0,             7, 7, 7,    0, 0, 0, 1);

    // Repeat counting: two hits broken by a miss, idle keeps the count, then three hits.
    applyStimulus("hit1",      1, 2'b01, 'h1c, 'h1c, 0, 0,       7, 8, 7,    0, 0, 0, 1);
    applyStimulus("hit2_hi",   1, 2'b11, 'h1c, 'h20, 'h20, 'h20, 8, 9, 8,    0, 0, 0, 1);
    applyStimulus("miss",      1, 2'b01, 'h20, 'h24, 0, 0,       10, 11, 10, 0, 0, 0, 1);
    applyStimulus("idle_keep", 1, 2'b00, 0, 0, 0, 0,             11, 11, 11, 0, 0, 0, 1);
    applyStimulus("hitA",      1, 2'b01, 'h24, 'h24, 0, 0,       11, 12, 11, 0, 0, 0, 1);
    applyStimulus("hitB",      1, 2'b10, 0, 0, 'h24, 'h24,       12, 12, 12, 0, 0, 0, 1);
    applyStimulus("idle_mid",  1, 2'b00, 0, 0, 0, 0,             13, 13, 13, 0, 0, 0, 1);
    applyStimulus("hitC",      1, 2'b01, 'h24, 'h24, 0, 0,       13, 14, 13, 0, 0, 0, 1);
    applyStimulus("pend",      1, 2'b11, 'h24, 'h24, 'h24, 'h24, 14, 15, 14, 0, 'h24, 0, 1);
    applyStimulus("halted",    1, 2'b11, 'h24, 'h24, 'h24, 'h24, 16, 17, 16, 1, 'h24, 0, 1);
    applyStimulus("frozen",    1, 2'b01, 'h24, 'h24, 0, 0,       16, 17, 16, 1, 'h24, 0, 1);
    applyStimulus("rst_req",   0, 2'b00, 0, 0, 0, 0,             16, 16, 16, 1, 'h24, 0, 1);
    applyStimulus("post_rst",  1, 2'b00, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0);

    // Watchdog: a commit after 7 idle cycles saves it, 8 idle cycles expire it.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("idle7",   1, 2'b00, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0);
    end
    applyStimulus("wd_commit", 1, 2'b01, 'h40, 'h44, 0, 0,       0, 1, 0,    0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("idle8",   1, 2'b00, 0, 0, 0, 0,             1, 1, 1,    0, 0, 0, 0);
    end
    applyStimulus("timeout",   1, 2'b01, 'h60, 'h60, 0, 0,       1, 2, 1,    0, 0, 1, 0);
    applyStimulus("to_frozen", 1, 2'b00, 0, 0, 0, 0,             1, 1, 1,    0, 0, 1, 0);
    applyStimulus("rst_to",    0, 2'b00, 0, 0, 0, 0,             1, 1, 1,    0, 0, 1, 0);
    applyStimulus("post_rst2", 1, 2'b00, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0);

    // jal x0,0 at 0x60, reset lands during the pending halt, then a clean re-halt.
    for (int k = 0; k < 3; k++) begin
      applyStimulus("loop60",  1, 2'b01, 'h60, 'h60, 0, 0,       k, k + 1, k, 0, 0, 0, 0);
    end
    applyStimulus("rst_pend",  0, 2'b00, 0, 0, 0, 0,             3, 3, 3,    0, 'h60, 0, 0);
    applyStimulus("post_rst3", 1, 2'b00, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("reloop",  1, 2'b01, 'h60, 'h60, 0, 0,       k, k + 1, k, 0, 0, 0, 0);
    end
    applyStimulus("pend2",     1, 2'b00, 0, 0, 0, 0,             3, 3, 3,    0, 'h60, 0, 0);
    applyStimulus("rehalt",    1, 2'b00, 0, 0, 0, 0,             3, 3, 3,    1, 'h60, 0, 0);
    applyStimulus("hold",      1, 2'b00, 0, 0, 0, 0,             3, 3, 3,    1, 'h60, 0, 0);

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
